// File: rtl/led_activity_pkg.sv
// led_activity_pkg: shared constants and helpers for the LED conditioning stage.
//   MODE_LEVEL / MODE_STRETCH : per-channel mode encodings
//   TICK_HZ                   : rate of the shared stretch time base
//   cycles_per_tick()         : clock cycles in one time-base period
package led_activity_pkg;

  localparam logic MODE_LEVEL   = 1'b0;
  localparam logic MODE_STRETCH = 1'b1;

  localparam int TICK_HZ = 1000;

  // Number of clk cycles between consecutive 1 ms ticks.
  function automatic int cycles_per_tick(input int clk_hz);
    return clk_hz / TICK_HZ;
  endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// led_stretch_ch: one LED channel -- input synchroniser, edge detect and a
// retriggerable stretch counter that decrements on the shared 1 ms tick.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   tick       : 1-cycle pulse every 1 ms from the shared prescaler
//   act_in     : raw (possibly asynchronous) activity/level input
//   mode       : MODE_LEVEL passes the synchronised level, MODE_STRETCH the flash
//   val        : channel value before brightness gating
module led_stretch_ch
  import led_activity_pkg::*;
#(
  parameter int STRETCH_MS = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic act_in,
  input  logic mode,
  output logic val
);

  localparam int CW = $clog2(STRETCH_MS + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(STRETCH_MS);

  logic          s1_r;
  logic          s2_r;
  logic          s3_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          edge_s;
  logic          lit_s;

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= act_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Stretch counter next state: an edge reload beats a coincident tick.
  always_comb begin
    edge_s    = s2_r ^ s3_r;
    cnt_nxt_s = cnt_r;
    if (edge_s) begin
      cnt_nxt_s = LOAD_VAL;
    end else if (tick && (cnt_r != {CW{1'b0}})) begin
      cnt_nxt_s = cnt_r - CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stretch counter register; runs in both modes so a mode switch shows live state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Channel value selection.
  always_comb begin
    lit_s = (cnt_r != {CW{1'b0}});
    if (mode == MODE_STRETCH) begin
      val = lit_s;
    end else begin
      val = s2_r;
    end
  end

endmodule

// File: rtl/led_activity.sv
// led_activity: LED conditioning between core status/pad signals and board LEDs.
// Each channel passes a synchronised level or stretches activity into a
// retriggerable flash; lit LEDs share an optional global PWM brightness.
// Optional feature macro: LED_ACTIVITY_PWM_EN (PWM brightness gating).
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   act_in     : N_CH raw activity/level inputs (may be asynchronous)
//   mode       : N_CH per-channel mode, 0 = level, 1 = stretch
//   brightness : global duty brightness/2^W_PWM (ignored without the PWM macro)
//   led        : N_CH registered active-high LED drive
module led_activity
  import led_activity_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int CLK_HZ     = 12_000_000,
  parameter int STRETCH_MS = 50,
  parameter int W_PWM      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  act_in,
  input  logic [N_CH-1:0]  mode,
  input  logic [W_PWM-1:0] brightness,
  output logic [N_CH-1:0]  led
);

  localparam int CPT = cycles_per_tick(CLK_HZ);
  localparam int PW  = (CPT > 1) ? $clog2(CPT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CPT - 1);

  if ((CLK_HZ % TICK_HZ) != 0) begin : g_bad_clk_hz
    $error("led_activity: CLK_HZ must be a multiple of 1000");
  end
  if (STRETCH_MS < 1) begin : g_bad_stretch
    $error("led_activity: STRETCH_MS must be at least 1");
  end

  logic [PW-1:0]   presc_r;
  logic            tick_s;
  logic [N_CH-1:0] val_s;
  logic            pwm_on_s;
  logic [N_CH-1:0] led_r;

  // Shared 1 ms prescaler; tick marks the wrap cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  assign tick_s = (presc_r == PRESC_MAX);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_stretch_ch #(
      .STRETCH_MS(STRETCH_MS)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_s),
      .act_in(act_in[i]),
      .mode  (mode[i]),
      .val   (val_s[i])
    );
  end

`ifdef LED_ACTIVITY_PWM_EN
  logic [W_PWM-1:0] pc_r;
  logic [W_PWM-1:0] bri_q_r;

  // PWM period counter; brightness is latched only at the wrap so duty never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r    <= {W_PWM{1'b0}};
      bri_q_r <= {W_PWM{1'b1}};
    end else begin
      pc_r <= pc_r + W_PWM'(1);
      if (pc_r == {W_PWM{1'b1}}) begin
        bri_q_r <= brightness;
      end else begin
        bri_q_r <= bri_q_r;
      end
    end
  end

  assign pwm_on_s = (pc_r < bri_q_r);
`else
  logic unused_brightness_s;

  assign unused_brightness_s = ^brightness;
  assign pwm_on_s            = 1'b1;
`endif

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_r <= {N_CH{1'b0}};
    end else begin
      led_r <= val_s & {N_CH{pwm_on_s}};
    end
  end

  assign led = led_r;

endmodule

// File: tb/tb_led_activity.sv
// Self-checking bench for led_activity (N_CH=2, 10 cycles/ms, 5 ms flash).
// Reference model: every output is derived from the recorded input history.
// Edges are numbered from 1 after the last reset edge; samp_h[n] is act_in as
// sampled at edge n. A channel reloads at edge L when samp[L-2] != samp[L-3];
// ticks land on edges that are multiples of 10, so the flash is still lit
// after edge t-1 iff fewer than 5 ticks fall in (L, t-1].
module tb_led_activity;

  localparam int N    = 2;
  localparam int CLKF = 10_000;
  localparam int S    = 5;
  localparam int W    = 4;
  localparam int P    = 10;
  localparam int MAXN = 4096;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] act_in = '0;
  logic [N-1:0] mode = '0;
  logic [W-1:0] brightness = 4'hF;
  logic [N-1:0] led;

  led_activity #(
    .N_CH(N), .CLK_HZ(CLKF), .STRETCH_MS(S), .W_PWM(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .act_in(act_in), .mode(mode),
    .brightness(brightness), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [N-1:0] samp_h [0:MAXN];
  logic [N-1:0] mode_h [0:MAXN];
  logic [W-1:0] bri_h  [0:MAXN];

  // per-sequence observation counters
  int           seq_i;
  int           hi_cnt [N];
  int           rise_i [N];
  int           rises  [N];
  logic [N-1:0] prev_led;

  typedef struct {
    logic [N-1:0] act;
    logic [N-1:0] md;
    logic [N-1:0] exp_led;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [N-1:0] samp_at(input int k);
    if (k < 1) return '0;
    return samp_h[k];
  endfunction

  function automatic logic [N-1:0] exp_led(input int t);
    logic [N-1:0] r;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         v;
    logic         on;
    int           pc;
    int           bq;
    r  = '0;
    on = 1'b1;
`ifdef LED_ACTIVITY_PWM_EN
    pc = (t - 1) % 16;
    bq = 15;
    for (int w = t - 1; w >= 1; w--) begin
      if (w % 16 == 0) begin
        bq = int'(bri_h[w]);
        break;
      end
    end
    on = (pc < bq);
`else
    pc = 0;
    bq = 0;
`endif
    for (int c = 0; c < N; c++) begin
      v = 1'b0;
      if (mode_h[t][c]) begin
        for (int L = t - 1; L >= 1; L--) begin
          a = samp_at(L - 2);
          b = samp_at(L - 3);
          if (a[c] != b[c]) begin
            v = (((t - 1) / P - L / P) < S);
            break;
          end
        end
      end else begin
        a = samp_at(t - 2);
        v = a[c];
      end
      r[c] = v & on;
    end
    return r;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, n, got, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, record them, land 1 ns after the rising edge.
  task automatic step(input logic [N-1:0] a, input logic [N-1:0] m, input logic [W-1:0] b);
    #4;
    rst_n      = 1'b1;
    act_in     = a;
    mode       = m;
    brightness = b;
    if (n + 1 > MAXN) begin
      $display("FAIL history_overflow edge=%0d", n);
      $fatal(1, "history overflow");
    end
    samp_h[n+1] = a;
    mode_h[n+1] = m;
    bri_h[n+1]  = b;
    @(posedge clk);
    #1;
    n = n + 1;
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] m, input logic [W-1:0] b,
                     input int cyc);
    for (int i = 0; i < cyc; i++) begin
      step(a, m, b);
      check("model_led", int'(led), int'(exp_led(n)));
      for (int c = 0; c < N; c++) begin
        if (led[c]) begin
          hi_cnt[c]++;
          if (rise_i[c] < 0) rise_i[c] = seq_i;
          if (!prev_led[c]) rises[c]++;
        end
      end
      prev_led = led;
      seq_i++;
    end
  endtask

  task automatic seq_start();
    seq_i    = 0;
    prev_led = '0;
    for (int c = 0; c < N; c++) begin
      hi_cnt[c] = 0;
      rise_i[c] = -1;
      rises[c]  = 0;
    end
  endtask

  task automatic do_reset(input int cyc);
    #4;
    rst_n = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      check("reset_led", int'(led), 0);
    end
    n = 0;
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rm;
    logic [W-1:0] rb;

    // level-mode vectors straight after reset: led follows act_in two entries later
    tbl[0] = '{act: 2'b00, md: 2'b00, exp_led: 2'b00};
    tbl[1] = '{act: 2'b01, md: 2'b00, exp_led: 2'b00};
    tbl[2] = '{act: 2'b10, md: 2'b00, exp_led: 2'b00};
    tbl[3] = '{act: 2'b11, md: 2'b00, exp_led: 2'b01};
    tbl[4] = '{act: 2'b00, md: 2'b00, exp_led: 2'b10};
    tbl[5] = '{act: 2'b00, md: 2'b00, exp_led: 2'b11};
    tbl[6] = '{act: 2'b10, md: 2'b00, exp_led: 2'b00};
    tbl[7] = '{act: 2'b01, md: 2'b00, exp_led: 2'b00};

    @(posedge clk);
    #1;
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].act, tbl[i].md, 4'hF);
      check("table_led", int'(led), int'(tbl[i].exp_led));
    end

    // input held high through reset: exactly one flash after release
    act_in = 2'b01;
    mode   = 2'b01;
    do_reset(3);
    seq_start();
    run(2'b01, 2'b01, 4'hF, 60);
`ifndef LED_ACTIVITY_PWM_EN
    check_range("reset_flash_len", hi_cnt[0], 40, 50);
    check("reset_flash_count", rises[0], 1);
    check("reset_flash_ch1", hi_cnt[1], 0);
`endif

    // single 1-cycle pulse in stretch mode
    run(2'b00, 2'b01, 4'hF, 70);
    seq_start();
    run(2'b01, 2'b01, 4'hF, 1);
    run(2'b00, 2'b01, 4'hF, 60);
`ifndef LED_ACTIVITY_PWM_EN
    check("pulse_rise_delay", rise_i[0], 3);
    check_range("pulse_flash_len", hi_cnt[0], 42, 51);
    check("pulse_ch1_quiet", hi_cnt[1], 0);
`endif

    // retrigger: four pulses 20 cycles apart keep the LED solid
    seq_start();
    for (int p = 0; p < 4; p++) begin
      run(2'b01, 2'b01, 4'hF, 1);
      run(2'b00, 2'b01, 4'hF, 19);
    end
    run(2'b00, 2'b01, 4'hF, 60);
`ifndef LED_ACTIVITY_PWM_EN
    check("retrigger_solid", rises[0], 1);
    check_range("retrigger_len", hi_cnt[0], 102, 111);
`endif

    // level mode: 7-cycle high on channel 1
    run(2'b00, 2'b00, 4'hF, 5);
    seq_start();
    run(2'b10, 2'b00, 4'hF, 7);
    run(2'b00, 2'b00, 4'hF, 10);
`ifndef LED_ACTIVITY_PWM_EN
    check("level_len", hi_cnt[1], 7);
    check("level_delay", rise_i[1], 2);
    check("level_ch0_quiet", hi_cnt[0], 0);
`endif

    // edge reload coinciding with a tick: full 5 ms flash
    run(2'b00, 2'b01, 4'hF, 2);
    while (((n + 3) % P) != 0) run(2'b00, 2'b01, 4'hF, 1);
    seq_start();
    run(2'b01, 2'b01, 4'hF, 70);
`ifndef LED_ACTIVITY_PWM_EN
    check("tick_edge_len", hi_cnt[0], 50);
    check("tick_edge_rise", rise_i[0], 3);
`endif

    // reset in the middle of a flash
    run(2'b00, 2'b01, 4'hF, 10);
`ifndef LED_ACTIVITY_PWM_EN
    check("flash_before_reset", int'(led[0]), 1);
`endif
    do_reset(2);
    seq_start();
    run(2'b00, 2'b01, 4'hF, 20);
    check("after_reset_dark", hi_cnt[0] + hi_cnt[1], 0);

`ifdef LED_ACTIVITY_PWM_EN
    // duty 4/16, change to 12/16 mid-period, then off
    run(2'b11, 2'b00, 4'd4, 40);
    run(2'b11, 2'b00, 4'd12, 40);
    run(2'b11, 2'b00, 4'd0, 16);
    seq_start();
    run(2'b11, 2'b00, 4'd0, 32);
    check("pwm_zero_dark", hi_cnt[0] + hi_cnt[1], 0);
`endif

    // randomized traffic against the model
    ra = '0;
    rm = 2'b01;
    rb = 4'hF;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) ra = ra ^ N'($urandom_range(1, 3));
      if ($urandom_range(0, 60) == 0) rm = N'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) rb = W'($urandom_range(0, 15));
      run(ra, rm, rb, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
